bsg_link_oddr_phy: RTL and testbench
====================================

BSG_LINK_ODDR_PHY -- requirements
Module: bsg_link_oddr_phy

Interface
REQ-001 SHALL have parameter: width_p, default 64, width of one DDR output half-word (pin count).
REQ-002 SHALL have port: clk_i  input  1  core clock, 2x the rate of the forwarded link clock, rising edge only.
REQ-003 SHALL have port: reset_i  input  1  reset.
REQ-004 SHALL have port: data_i  input  2*width_p  word to send; [width_p-1:0] is the low half, sent first.
REQ-005 SHALL have port: valid_i  input  1  data_i valid.
REQ-006 SHALL have port: ready_o  output  1  block accepts data_i this cycle.
REQ-007 SHALL have port: data_r_o  output  width_p  registered pin data.
REQ-008 SHALL have port: clk_r_o  output  1  registered forwarded link clock.
REQ-009 SHALL use one clock and synchronous, active-high reset: clk_i and reset_i, with no negedge or derived-clock logic.

Function
REQ-010 SHALL keep a phase bit phase_r that toggles on every clk_i edge when not in reset.
REQ-011 SHALL drive clk_r_o as follows: on a phase_r==0 edge, clk_r_o<=1; on a phase_r==1 edge, clk_r_o<=0. This gives a 50% duty clock at clk_i/2, free-running after reset whether or not data is pending.
REQ-012 SHALL hold a one-word buffer: buf_r (2*width_p) and buf_v_r.
REQ-013 SHALL drive ready_o = ~reset_i & (~buf_v_r | ~phase_r), i.e. the block is ready when the buffer is empty or the buffer drains this edge.
REQ-014 SHALL treat a handshake as valid_i & ready_o at a clk_i edge, which loads buf_r<=data_i and sets buf_v_r=1; data_i is ignored when ready_o=0.
REQ-015 SHALL, on a phase_r==0 edge with buf_v_r=1, perform three updates:
  - data_r_o<=buf_r[width_p-1:0];
  - hi_r<=buf_r[2*width_p-1:width_p];
  - hi_v_r<=1.
  The buffer is consumed: buf_v_r<=0 unless a handshake occurs on the same edge, in which case buf_v_r stays 1 with the new word.
REQ-016 SHALL, on a phase_r==0 edge with buf_v_r=0, hold data_r_o and set hi_v_r<=0.
REQ-017 SHALL, on a phase_r==1 edge with hi_v_r=1, set data_r_o<=hi_r; with hi_v_r=0, hold data_r_o.
REQ-018 SHALL launch the low half with the clk_r_o rising transition and the high half with the falling transition, matching a DDR receiver that captures the low half on rising and the high half on falling link-clock edges (centering delay is external to this block).
REQ-019 SHALL have these latency properties:
  - A word accepted on a phase_r==1 edge into an empty buffer appears (low half) on data_r_o after the next edge and its high half one edge later.
  - A word accepted on a phase_r==0 edge appears two edges later.
REQ-020 SHALL sustain a throughput of one word per 2 clk_i cycles with valid_i held high, with no gaps on data_r_o.
REQ-021 SHALL never drop, duplicate or reorder words; each accepted word produces exactly one low and one high half-word in order.
REQ-022 SHALL, when idle, keep clk_r_o toggling and hold data_r_o at the last high half sent.

Reset
REQ-023 SHALL, while reset_i=1 at an edge, set:
  - phase_r=0, clk_r_o=0, data_r_o=0;
  - buf_v_r=0, hi_v_r=0, buf_r=0, hi_r=0.
  ready_o=0 while reset_i=1.
REQ-024 SHALL, on reset asserted mid-word (including between the low and high halves), discard the pending half/word and emit no further halves of it.
REQ-025 SHALL produce, on the first edge after reset deasserts, phase_r=1 and clk_r_o=1.

Verification
REQ-026 SHALL cover reset: hold reset_i 3 cycles with valid_i=1 -> ready_o=0, data_r_o=0, clk_r_o=0 throughout; after release, clk_r_o sequence 1,0,1,0.
REQ-027 SHALL cover a single word: width_p=8, send data_i=16'hB3A5 once -> data_r_o=8'hA5 while clk_r_o=1, then 8'hB3 while clk_r_o=0, then data_r_o holds 8'hB3.
REQ-028 SHALL cover back-to-back streaming: valid_i=1 for 4 words 0x0100,0x0302,0x0504,0x0706 -> data_r_o sequence 00,01,02,03,04,05,06,07 on consecutive cycles with ready_o pattern 1,0 repeating after the first fill.
REQ-029 SHALL cover backpressure: buffer full on a phase_r==1 edge -> ready_o=0, data_i changes are ignored, and the buffered word is sent unaltered.
REQ-030 SHALL cover reset mid-word: assert reset_i on the edge after the low half 8'h11 of 16'h2211 -> 8'h22 is never driven and data_r_o=0.
REQ-031 SHALL cover a random stream: random valid_i over 10k cycles -> a scoreboard deserializing (rising=low, falling=high) matches the accepted words exactly.

Source files
------------

// File: rtl/bsg_link_oddr_phy.sv
// Source-synchronous DDR output PHY: serializes one 2*width_p word per two clk_i
// cycles onto width_p pins, low half on the forwarded-clock rise, high half on the fall.
module bsg_link_oddr_phy #(
  parameter int width_p = 64
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [2*width_p-1:0] data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [width_p-1:0]   data_r_o,
  output logic                 clk_r_o
);

  localparam int unsigned half_w_lp = width_p;
  localparam int unsigned word_w_lp = 2 * width_p;

  logic                 phase_q, phase_d;
  logic                 clk_q, clk_d;
  logic [half_w_lp-1:0] data_q, data_d;
  logic [word_w_lp-1:0] buf_q, buf_d;
  logic                 buf_v_q, buf_v_d;
  logic [half_w_lp-1:0] hi_q, hi_d;
  logic                 hi_v_q, hi_v_d;
  logic                 hs_c;

  // Ready when the buffer is empty or is being drained on this (phase 0) edge.
  assign ready_o = ~reset_i & (~buf_v_q | ~phase_q);
  assign hs_c    = valid_i & ready_o;

  // Next-state: phase 0 launches the low half, phase 1 the high half.
  always_comb begin
    phase_d = ~phase_q;
    clk_d   = ~phase_q;
    data_d  = data_q;
    buf_d   = hs_c ? data_i : buf_q;
    buf_v_d = buf_v_q;
    hi_d    = hi_q;
    hi_v_d  = hi_v_q;
    if (!phase_q) begin
      if (buf_v_q) begin
        data_d = buf_q[half_w_lp-1:0];
        hi_d   = buf_q[word_w_lp-1:half_w_lp];
        hi_v_d = 1'b1;
      end else begin
        hi_v_d = 1'b0;
      end
      buf_v_d = hs_c;
    end else begin
      if (hi_v_q) begin
        data_d = hi_q;
      end
      buf_v_d = buf_v_q | hs_c;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      phase_q <= 1'b0;
      clk_q   <= 1'b0;
      data_q  <= '0;
      buf_q   <= '0;
      buf_v_q <= 1'b0;
      hi_q    <= '0;
      hi_v_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      clk_q   <= clk_d;
      data_q  <= data_d;
      buf_q   <= buf_d;
      buf_v_q <= buf_v_d;
      hi_q    <= hi_d;
      hi_v_q  <= hi_v_d;
    end
  end

  assign data_r_o = data_q;
  assign clk_r_o  = clk_q;

endmodule

// File: tb/tb_bsg_link_oddr_phy.sv
// Directed and random-stream bench for bsg_link_oddr_phy at width_p=8.
module tb_bsg_link_oddr_phy;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [15:0] data_i;
  logic        valid_i;
  logic        ready_o;
  logic [7:0]  data_r_o;
  logic        clk_r_o;

  int n_cmp = 0;
  int n_err = 0;

  bsg_link_oddr_phy #(.width_p(8)) dut (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .data_i   (data_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .data_r_o (data_r_o),
    .clk_r_o  (clk_r_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [15:0] words [4];
  logic [7:0]  exp_str [11];
  logic [15:0] q [$];
  logic [15:0] w;
  logic [7:0]  exp_d, hv;
  logic        ph, hp, er, acc, rd;
  int          k;

  initial begin
    words   = '{16'h0100, 16'h0302, 16'h0504, 16'h0706};
    exp_str = '{8'hB3, 8'hB3, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h07};

    // Reset held three cycles with valid asserted.
    reset_i = 1'b1;
    valid_i = 1'b1;
    data_i  = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_ready", 16'(ready_o), 16'h0);
      chk("rst_data", 16'(data_r_o), 16'h0);
      chk("rst_clk", 16'(clk_r_o), 16'h0);
    end
    reset_i = 1'b0;
    valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_clk", 16'(clk_r_o), 16'(i % 2 == 0));
      chk("post_rst_data", 16'(data_r_o), 16'h0);
    end

    // Single word accepted on a phase 0 edge.
    data_i  = 16'hB3A5;
    valid_i = 1'b1;
    #1 chk("single_ready", 16'(ready_o), 16'h1);
    tick();
    valid_i = 1'b0;
    #1 chk("single_full_ready", 16'(ready_o), 16'h0);
    chk("single_e1_data", 16'(data_r_o), 16'h00);
    tick();
    chk("single_e2_data", 16'(data_r_o), 16'h00);
    tick();
    chk("single_lo", 16'(data_r_o), 16'hA5);
    chk("single_lo_clk", 16'(clk_r_o), 16'h1);
    tick();
    chk("single_hi", 16'(data_r_o), 16'hB3);
    chk("single_hi_clk", 16'(clk_r_o), 16'h0);
    tick();
    chk("single_hold1", 16'(data_r_o), 16'hB3);
    tick();
    chk("single_hold2", 16'(data_r_o), 16'hB3);

    // Back-to-back streaming of four words.
    k = 0;
    for (int e = 0; e < 11; e++) begin
      valid_i = (k < 4);
      data_i  = (k < 4) ? words[k] : 16'h0;
      #1;
      if (e < 8) chk("stream_ready", 16'(ready_o), 16'(e % 2 == 0));
      rd = ready_o;
      tick();
      if (valid_i && rd) k++;
      chk("stream_data", 16'(data_r_o), 16'(exp_str[e]));
      chk("stream_clk", 16'(clk_r_o), 16'(e % 2 == 0));
    end

    // Backpressure: fill on phase 1, refill on phase 0, then full on phase 1.
    valid_i = 1'b1;
    data_i  = 16'hC4D5;
    #1 chk("bp_ready_e12", 16'(ready_o), 16'h1);
    tick();
    data_i = 16'h9A8B;
    #1 chk("bp_ready_e13", 16'(ready_o), 16'h1);
    chk("bp_e12_data", 16'(data_r_o), 16'h07);
    tick();
    chk("bp_lo1", 16'(data_r_o), 16'hD5);
    data_i = 16'hEEEE;
    #1 chk("bp_ready_full", 16'(ready_o), 16'h0);
    tick();
    chk("bp_hi1", 16'(data_r_o), 16'hC4);
    valid_i = 1'b0;
    tick();
    chk("bp_lo2", 16'(data_r_o), 16'h8B);
    tick();
    chk("bp_hi2", 16'(data_r_o), 16'h9A);
    tick();
    chk("bp_hold", 16'(data_r_o), 16'h9A);

    // Reset asserted right after the low half.
    valid_i = 1'b1;
    data_i  = 16'h2211;
    tick();
    valid_i = 1'b0;
    tick();
    chk("midrst_lo", 16'(data_r_o), 16'h11);
    reset_i = 1'b1;
    #1 chk("midrst_ready", 16'(ready_o), 16'h0);
    tick();
    chk("midrst_data", 16'(data_r_o), 16'h00);
    chk("midrst_clk", 16'(clk_r_o), 16'h0);
    reset_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("midrst_after", 16'(data_r_o), 16'h00);
    end

    // Random stream against a deserializing scoreboard.
    ph    = 1'b0;
    hp    = 1'b0;
    hv    = 8'h00;
    exp_d = 8'h00;
    for (int c = 0; c < 10000; c++) begin
      valid_i = 1'($urandom_range(0, 1));
      data_i  = 16'($urandom);
      #1;
      er = (q.size() == 0) || !ph;
      chk("rnd_ready", 16'(ready_o), 16'(er));
      acc = valid_i && er;
      tick();
      if (!ph) begin
        if (q.size() > 0) begin
          w     = q.pop_front();
          exp_d = w[7:0];
          hv    = w[15:8];
          hp    = 1'b1;
        end else begin
          hp = 1'b0;
        end
      end else if (hp) begin
        exp_d = hv;
      end
      if (acc) q.push_back(data_i);
      chk("rnd_data", 16'(data_r_o), 16'(exp_d));
      chk("rnd_clk", 16'(clk_r_o), 16'(!ph));
      ph = ~ph;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
